// File: rtl/chan_scan_mux.sv
// chan_scan_mux: registered N-channel W-bit multiplexer with manual select
// and auto-scan modes.
//
// The output is tagged with the channel that produced it and a valid flag.
// In scan mode each channel is held for DWELL output cycles. sweep pulses
// on the last dwell cycle of channel CHANNELS-1.
//
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-high reset
//   a     - packed inputs, channel k = a[k*WIDTH +: WIDTH]
//   sel   - manual channel select, also the scan start channel
//   mode  - 0 = manual, 1 = scan
//   en    - enable; 0 freezes y/ch and drops valid
//   y     - registered selected data
//   ch    - channel index that produced y
//   valid - y/ch hold a legitimate sample from the last enabled cycle
//   sweep - one-cycle pulse that ends a full scan rotation
module chan_scan_mux #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned SELW     = 3,
  parameter int unsigned DWELL    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] a,
  input  logic [SELW-1:0]           sel,
  input  logic                      mode,
  input  logic                      en,
  output logic [WIDTH-1:0]          y,
  output logic [SELW-1:0]           ch,
  output logic                      valid,
  output logic                      sweep
);

  localparam int unsigned CNTW = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

  state_t            state, state_n;
  logic [SELW-1:0]   ptr, ptr_n;
  logic [CNTW-1:0]   cnt, cnt_n;
  logic [WIDTH-1:0]  y_n;
  logic [SELW-1:0]   ch_n;
  logic              valid_n, sweep_n;
  logic              sel_ok;
  logic [SELW-1:0]   cur_ptr;
  logic [CNTW-1:0]   cur_cnt;

  // Compare-based mux so select codes beyond CHANNELS-1 never index out of range
  function automatic logic [WIDTH-1:0] pick(input logic [SELW-1:0]           idx,
                                            input logic [CHANNELS*WIDTH-1:0] bus);
    pick = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (idx == SELW'(k)) pick = bus[k*WIDTH +: WIDTH];
    end
  endfunction

  // Extra bit keeps the compare meaningful when 2**SELW == CHANNELS
  assign sel_ok = ({1'b0, sel} < (SELW+1)'(CHANNELS));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state and next output/datapath values
  always_comb begin
    state_n = IDLE;
    y_n     = y;
    ch_n    = ch;
    valid_n = 1'b0;
    sweep_n = 1'b0;
    ptr_n   = ptr;
    cnt_n   = cnt;
    cur_ptr = ptr;
    cur_cnt = cnt;

    if (en) state_n = mode ? SCAN : MANUAL;

    case (state_n)
      MANUAL: begin
        cnt_n = '0;
        if (sel_ok) begin
          y_n     = pick(sel, a);
          ch_n    = sel;
          valid_n = 1'b1;
        end
      end
      SCAN: begin
        // Entry is the first dwell cycle of the start channel
        if (state != SCAN) begin
          cur_ptr = sel_ok ? sel : '0;
          cur_cnt = '0;
        end
        y_n     = pick(cur_ptr, a);
        ch_n    = cur_ptr;
        valid_n = 1'b1;
        if (cur_cnt == CNTW'(DWELL - 1)) begin
          cnt_n = '0;
          if (cur_ptr == SELW'(CHANNELS - 1)) begin
            ptr_n   = '0;
            sweep_n = 1'b1;
          end else begin
            ptr_n = cur_ptr + SELW'(1);
          end
        end else begin
          cnt_n = cur_cnt + CNTW'(1);
          ptr_n = cur_ptr;
        end
      end
      default: ;
    endcase
  end

  // Output and scan-position registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y     <= '0;
      ch    <= '0;
      valid <= 1'b0;
      sweep <= 1'b0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      y     <= y_n;
      ch    <= ch_n;
      valid <= valid_n;
      sweep <= sweep_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
    end
  end

endmodule
